mod_n_updown_counter: RTL and testbench



---
 rtl/mod_n_updown_counter_if.sv | 33 +++
 rtl/mod_n_updown_counter.sv | 91 +++++++++
 tb/tb_mod_n_updown_counter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mod_n_updown_counter_if.sv
// Counter control/status bundle: master drives enable, direction, mode and load; slave returns count and flags.
// load_err is present only when MODN_CNT_LOADCHK_EN is defined.
interface mod_n_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             sat;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;
`ifdef MODN_CNT_LOADCHK_EN
   logic             load_err;
`endif

   modport master (
      output en, up, sat, load, load_value,
`ifdef MODN_CNT_LOADCHK_EN
      input  load_err,
`endif
      input  q, tc, wrap
   );

   modport slave (
      input  en, up, sat, load, load_value,
`ifdef MODN_CNT_LOADCHK_EN
      output load_err,
`endif
      output q, tc, wrap
   );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with load clamp, wrap/saturate mode, combinational tc and a registered wrap pulse.
// Latency 1 cycle to q/wrap, tc is zero-latency; no backpressure. Sticky load_err only with MODN_CNT_LOADCHK_EN.
module mod_n_updown_counter #(
   parameter int WIDTH       = 4,
   parameter int MODULUS     = 10,
   parameter int RESET_VALUE = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   mod_n_updown_counter_if.slave  cnt_if
);
   // MODULUS-1 is formed in 32 bits before narrowing, so MODULUS == 2^WIDTH cannot overflow.
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("mod_n_updown_counter: WIDTH out of range");
   end
   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
      $error("mod_n_updown_counter: MODULUS out of range");
   end
   if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_rst
      $error("mod_n_updown_counter: RESET_VALUE out of range");
   end

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             at_max;
   logic             at_zero;
   logic             load_oor;

   assign at_max   = (q_q == MAX_VAL);
   assign at_zero  = (q_q == '0);
   assign load_oor = (cnt_if.load_value > MAX_VAL);

   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (cnt_if.load) begin
         q_d = load_oor ? MAX_VAL : cnt_if.load_value;
      end else if (cnt_if.en) begin
         if (cnt_if.up) begin
            if (!at_max) begin
               q_d = q_q + ONE;
            end else if (!cnt_if.sat) begin
               q_d    = '0;
               wrap_d = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               q_d = q_q - ONE;
            end else if (!cnt_if.sat) begin
               q_d    = MAX_VAL;
               wrap_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q_q    <= RST_VAL;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt_if.q    = q_q;
   assign cnt_if.wrap = wrap_q;
   assign cnt_if.tc   = cnt_if.up ? at_max : at_zero;

`ifdef MODN_CNT_LOADCHK_EN
   logic load_err_q, load_err_d;

   // Sticky: only reset clears it, later valid loads leave it set.
   assign load_err_d = load_err_q | (cnt_if.load & load_oor);

   always_ff @(posedge clock) begin
      if (reset) begin
         load_err_q <= 1'b0;
      end else begin
         load_err_q <= load_err_d;
      end
   end

   assign cnt_if.load_err = load_err_q;
`endif
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench for mod_n_updown_counter: a MOD-10 instance and a full-range MOD-8 instance.
module tb_mod_n_updown_counter;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic reset8 = 1'b0;

   always #5 clock = ~clock;

   mod_n_updown_counter_if #(.WIDTH(4)) c_if ();
   mod_n_updown_counter_if #(.WIDTH(3)) f_if ();

   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_dut (
      .clock  (clock),
      .reset  (reset),
      .cnt_if (c_if.slave)
   );

   mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VALUE(0)) u_full (
      .clock  (clock),
      .reset  (reset8),
      .cnt_if (f_if.slave)
   );

   typedef struct {
      string tag;
      int    q;
      int    wrap;
      int    tc;
      int    lerr;
   } exp_t;

   exp_t sb[$];
   exp_t sb8[$];

   int n_chk  = 0;
   int n_pass = 0;
   int m_q    = 0;
   int m_lerr = 0;
   int f_q    = 0;
   int f_wraps = 0;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_chk++;
      if (obs == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
   endtask

   // Reference behaviour written with modular arithmetic.
   function automatic void model(input int md, input int q_in, input bit rst, input bit ld,
                                 input bit e, input bit u, input bit s, input int lv,
                                 output int q_out, output int w);
      q_out = q_in;
      w     = 0;
      if (rst) q_out = 0;
      else if (ld) q_out = (lv > md - 1) ? md - 1 : lv;
      else if (e && u) begin
         if (!(q_in == md - 1 && s)) begin
            w     = (q_in == md - 1) ? 1 : 0;
            q_out = (q_in + 1) % md;
         end
      end else if (e) begin
         if (!(q_in == 0 && s)) begin
            w     = (q_in == 0) ? 1 : 0;
            q_out = (q_in + md - 1) % md;
         end
      end
   endfunction

   task automatic step(input string tag, input bit rst, input bit ld, input bit e,
                       input bit u, input bit s, input int lv);
      exp_t ex, got;
      int nq, w;
      @(negedge clock);
      reset = rst;
      c_if.load = ld; c_if.en = e; c_if.up = u; c_if.sat = s;
      c_if.load_value = 4'(lv);
      model(10, m_q, rst, ld, e, u, s, lv, nq, w);
      m_q = nq;
      if (rst) m_lerr = 0;
      else if (ld && lv >= 10) m_lerr = 1;
      ex.tag = tag; ex.q = m_q; ex.wrap = w;
      ex.tc = u ? ((m_q == 9) ? 1 : 0) : ((m_q == 0) ? 1 : 0);
      ex.lerr = m_lerr;
      sb.push_back(ex);
      @(posedge clock);
      #1;
      got = sb.pop_front();
      chk({got.tag, ".q"}, int'(c_if.q), got.q);
      chk({got.tag, ".wrap"}, int'(c_if.wrap), got.wrap);
      chk({got.tag, ".tc"}, int'(c_if.tc), got.tc);
`ifdef MODN_CNT_LOADCHK_EN
      chk({got.tag, ".load_err"}, int'(c_if.load_err), got.lerr);
`endif
   endtask

   task automatic step8(input string tag, input bit rst, input bit e);
      exp_t ex, got;
      int nq, w;
      @(negedge clock);
      reset8 = rst;
      f_if.load = 1'b0; f_if.en = e; f_if.up = 1'b1; f_if.sat = 1'b0;
      f_if.load_value = '0;
      model(8, f_q, rst, 1'b0, e, 1'b1, 1'b0, 0, nq, w);
      f_q = nq;
      ex.tag = tag; ex.q = f_q; ex.wrap = w;
      ex.tc = (f_q == 7) ? 1 : 0; ex.lerr = 0;
      sb8.push_back(ex);
      @(posedge clock);
      #1;
      got = sb8.pop_front();
      if (f_if.wrap) f_wraps++;
      chk({got.tag, ".q"}, int'(f_if.q), got.q);
      chk({got.tag, ".wrap"}, int'(f_if.wrap), got.wrap);
      chk({got.tag, ".tc"}, int'(f_if.tc), got.tc);
   endtask

   initial begin
      c_if.en = 1'b0; c_if.up = 1'b1; c_if.sat = 1'b0; c_if.load = 1'b0; c_if.load_value = '0;
      f_if.en = 1'b0; f_if.up = 1'b1; f_if.sat = 1'b0; f_if.load = 1'b0; f_if.load_value = '0;

      // Reset then 12 up counts through the 9 -> 0 wrap.
      step("reset", 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 12; i++) step("up", 0, 0, 1, 1, 0, 0);
      step("hold", 0, 0, 0, 1, 0, 0);

      // Down wrap from 2 through 0 to 9.
      step("ld2", 0, 1, 0, 0, 0, 2);
      for (int i = 0; i < 4; i++) step("down", 0, 0, 1, 0, 0, 0);

      // Saturate at the top, then count back down.
      step("ld8", 0, 1, 0, 1, 1, 8);
      for (int i = 0; i < 3; i++) step("sat_up", 0, 0, 1, 1, 1, 0);
      for (int i = 0; i < 2; i++) step("sat_dn", 0, 0, 1, 0, 1, 0);
      step("ld0", 0, 1, 0, 0, 1, 0);
      step("sat_lo", 0, 0, 1, 0, 1, 0);

      // Out-of-range load clamps; flag is sticky until reset.
      step("ld13", 0, 1, 0, 1, 0, 13);
      step("ld3", 0, 1, 0, 1, 0, 3);
      step("rst_err", 1, 0, 0, 1, 0, 0);
      step("ld15", 0, 1, 0, 1, 0, 15);

      // Load beats enable; reset beats enable at the top.
      step("ld9", 0, 1, 0, 1, 0, 9);
      step("ld5_en", 0, 1, 1, 1, 0, 5);
      step("ld9b", 0, 1, 0, 1, 0, 9);
      step("rst_en", 1, 0, 1, 1, 0, 0);
      step("resume", 0, 0, 1, 1, 0, 0);

      // Direction reversal at the top bound gives no wrap.
      step("ld9c", 0, 1, 0, 1, 0, 9);
      step("rev", 0, 0, 1, 0, 0, 0);

      // Random mix with up/sat changing every cycle.
      for (int i = 0; i < 60; i++)
         step("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 15)));

      // Full-range modulus: 9 up counts wrap 7 -> 0 once.
      step8("f_rst", 1, 0);
      for (int i = 0; i < 9; i++) step8("f_up", 0, 1);
      chk("f_wrap_count", f_wraps, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
